ibex_counter_bank: RTL and testbench
====================================

Name: ibex_counter_bank

Overview:
Bank of NumCounters independently programmable event counters. Generalises the single CSR-writable counter with per-counter event selection, per-counter inhibit, sticky overflow flags and an overflow interrupt request. Sits in the CSR/performance-monitor area next to the core's CSR file; the CSR file owns address decode and drives indexed writes.

Parameters:
NumCounters, 4, number of counters (1..32)
CounterWidth, 40, implemented bits per counter (1..64); bits [63:CounterWidth] are read as 0
NumEvents, 16, number of event inputs (2..256); localparam EvSelW = $clog2(NumEvents)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
event_i  input  NumEvents  per-cycle event strobes
inhibit_i  input  NumCounters  per-counter count inhibit (mcountinhibit-style)
idx_i  input  $clog2(NumCounters) (min 1)  counter targeted by this cycle's write
cnt_we_i  input  1  write csr_wdata_i to bits [31:0] of counter idx_i
cnth_we_i  input  1  write csr_wdata_i to bits [63:32] of counter idx_i
evsel_we_i  input  1  write csr_wdata_i[EvSelW-1:0] to the event select of counter idx_i
ovf_clr_i  input  NumCounters  clear sticky overflow flags (one-hot or multi-hot)
ovf_ie_i  input  NumCounters  overflow interrupt enables
csr_wdata_i  input  32  write data
counter_val_o  output  NumCounters*64  counter values, counter k at [64k+63:64k]
evsel_o  output  NumCounters*EvSelW  current event selects
ovf_o  output  NumCounters  sticky overflow flags
irq_o  output  1  overflow interrupt request

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low, applied via rst_ni. All state resets to 0: counters, event selects, overflow flags. Therefore counter_val_o=0, evsel_o=0, ovf_o=0 and irq_o=0 while in reset and in the first cycle after reset release.
- Count condition for counter k: inc_k = event_i[evsel_k] & ~inhibit_i[k]. An evsel_k >= NumEvents never counts. Maximum one increment per cycle.
- Increment: counter_k <= counter_k + 1, modulo 2^CounterWidth. Visible on counter_val_o one cycle after the event strobe.
- Overflow: an increment with counter_k == all-ones (CounterWidth bits) wraps the counter to 0 and sets ovf_k on the same edge.
- Write to counter idx_i, registered on the next edge:
  - cnt_we_i loads bits [31:0], keeping bits [63:32].
  - cnth_we_i loads bits [63:32], keeping bits [31:0].
  - Bits at or above CounterWidth are discarded. cnth_we_i is a no-op when CounterWidth <= 32.
  - If both are asserted together, cnth_we_i wins.
- Priority on the written counter: the write wins over an increment in the same cycle. No overflow is set from that counter that cycle. Counters other than idx_i increment normally.
- idx_i >= NumCounters: all writes are ignored.
- evsel_we_i: takes effect for events from the next cycle. It may coincide with a counter write to the same index; both apply.
- ovf_clr_i[k]: clears ovf_k. If it coincides with a new overflow of counter k, set wins and ovf_k stays 1.
- irq_o = |(ovf_o & ovf_ie_i). Combinational from flops and the enable input; no extra latency.
- Reset mid-operation: all state returns to 0 immediately. No partial write survives.

Decomposition:
- Package ibex_counter_bank_pkg holds:
  - the EvSelW helper function;
  - the write-op enum (CNT_WR_NONE, CNT_WR_LO, CNT_WR_HI), decoded once from cnt_we_i/cnth_we_i.
- One sub-module per counter, ibex_counter_bank_ctr (generate loop), containing:
  - the counter flop;
  - the increment and wrap logic;
  - the overflow flag and event-select register.
- The top level holds the index decode and the irq_o reduction.

Test Plan:
- Reset: hold rst_ni=0 with events toggling -> all outputs 0. Release -> counting starts on the first enabled event edge.
- Count and select: evsel_0=3, pulse event_i[3] 5 cycles, event_i[2] 4 cycles -> counter 0 = 5. With inhibit_i[0]=1 for 2 of the 5 pulses -> 3.
- Wrap and overflow: CounterWidth=40, write lo=0xFFFFFFFF and hi=0xFF to counter 1, then one event -> counter 1 = 0 and ovf_o[1]=1. With ovf_ie_i[1]=1 -> irq_o=1 the same cycle ovf_o rises.
- Simultaneous events:
  - cnt_we_i with data 0x10 in the same cycle as an increment of counter 2 -> counter 2 = 0x10.
  - ovf_clr_i[1] in the same cycle as a new wrap -> ovf_o[1] stays 1.
- Width masking: CounterWidth=40, cnth_we_i data 0xFFFF_FFFF -> counter_val_o[63:40]=0 and [39:32]=0xFF.
- Out-of-range: NumCounters=3 (idx_i 2 bits), idx_i=3 with all write enables -> no counter or evsel change. evsel=NumEvents -> no counting under any events.

Source files
------------

// File: rtl/ibex_counter_bank_pkg.sv
// Shared types and width helpers for the event counter bank.
package ibex_counter_bank_pkg;

  typedef enum logic [1:0] {
    CNT_WR_NONE = 2'd0,
    CNT_WR_LO   = 2'd1,
    CNT_WR_HI   = 2'd2
  } cnt_wr_op_e;

  function automatic int evsel_width(input int num_events);
    return (num_events > 2) ? $clog2(num_events) : 1;
  endfunction

  function automatic int idx_width(input int num_counters);
    return (num_counters > 1) ? $clog2(num_counters) : 1;
  endfunction

  // A high-half write takes precedence when both halves are strobed together.
  function automatic cnt_wr_op_e decode_wr_op(input logic cnt_we, input logic cnth_we);
    if (cnth_we) return CNT_WR_HI;
    if (cnt_we)  return CNT_WR_LO;
    return CNT_WR_NONE;
  endfunction

endpackage

// File: rtl/ibex_counter_bank_ctr.sv
// One programmable event counter: value, event select and sticky overflow flag.
module ibex_counter_bank_ctr
  import ibex_counter_bank_pkg::*;
#(
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned EvSelW       = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 inhibit_i,
  input  logic                 sel_i,
  input  cnt_wr_op_e           wr_op_i,
  input  logic                 evsel_we_i,
  input  logic                 ovf_clr_i,
  input  logic [31:0]          wdata_i,
  output logic [63:0]          cnt_o,
  output logic [EvSelW-1:0]    evsel_o,
  output logic                 ovf_o
);

  localparam int unsigned EvPadW = 1 << EvSelW;

  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [EvSelW-1:0]       evsel_q, evsel_d;
  logic                    ovf_q, ovf_d, ovf_set;
  logic [EvPadW-1:0]       ev_pad;
  logic [63:0]             cnt_ext, wr_val;
  logic                    inc, wr_en;

  // Zero padding makes selects at or beyond NumEvents read a constant 0.
  assign ev_pad  = EvPadW'(event_i);
  assign inc     = ev_pad[evsel_q] & ~inhibit_i;
  assign wr_en   = sel_i & (wr_op_i != CNT_WR_NONE);
  assign cnt_ext = 64'(cnt_q);

  always_comb begin
    wr_val = cnt_ext;
    unique case (wr_op_i)
      CNT_WR_LO: wr_val[31:0]  = wdata_i;
      CNT_WR_HI: wr_val[63:32] = wdata_i;
      default:   ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (wr_en) begin
      cnt_d = CounterWidth'(wr_val);
    end else if (inc) begin
      cnt_d   = cnt_q + CounterWidth'(1);
      ovf_set = &cnt_q;
    end
  end

  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr_i);
  assign evsel_d = (sel_i & evsel_we_i) ? wdata_i[EvSelW-1:0] : evsel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      evsel_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      evsel_q <= evsel_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_o   = cnt_ext;
  assign evsel_o = evsel_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/ibex_counter_bank.sv
// Bank of CSR-writable event counters with overflow flags and interrupt request.
module ibex_counter_bank
  import ibex_counter_bank_pkg::*;
#(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16,
  localparam int unsigned EvSelW      = evsel_width(NumEvents),
  localparam int unsigned IdxW        = idx_width(NumCounters)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumEvents-1:0]          event_i,
  input  logic [NumCounters-1:0]        inhibit_i,
  input  logic [IdxW-1:0]               idx_i,
  input  logic                          cnt_we_i,
  input  logic                          cnth_we_i,
  input  logic                          evsel_we_i,
  input  logic [NumCounters-1:0]        ovf_clr_i,
  input  logic [NumCounters-1:0]        ovf_ie_i,
  input  logic [31:0]                   csr_wdata_i,
  output logic [NumCounters*64-1:0]     counter_val_o,
  output logic [NumCounters*EvSelW-1:0] evsel_o,
  output logic [NumCounters-1:0]        ovf_o,
  output logic                          irq_o
);

  cnt_wr_op_e wr_op;

  assign wr_op = decode_wr_op(cnt_we_i, cnth_we_i);

  for (genvar k = 0; k < NumCounters; k++) begin : g_ctr
    // An index beyond the bank matches no counter, so the write is dropped.
    logic sel;
    assign sel = (idx_i == IdxW'(k));

    ibex_counter_bank_ctr #(
      .CounterWidth (CounterWidth),
      .NumEvents    (NumEvents),
      .EvSelW       (EvSelW)
    ) u_ctr (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .event_i    (event_i),
      .inhibit_i  (inhibit_i[k]),
      .sel_i      (sel),
      .wr_op_i    (wr_op),
      .evsel_we_i (evsel_we_i),
      .ovf_clr_i  (ovf_clr_i[k]),
      .wdata_i    (csr_wdata_i),
      .cnt_o      (counter_val_o[64*k +: 64]),
      .evsel_o    (evsel_o[EvSelW*k +: EvSelW]),
      .ovf_o      (ovf_o[k])
    );
  end

  assign irq_o = |(ovf_o & ovf_ie_i);

endmodule

// File: tb/tb_ibex_counter_bank.sv
// Randomised and directed checks of the counter bank against a behavioural model.
module tb_ibex_counter_bank;

  localparam int NC = 3;
  localparam int CW = 40;
  localparam int NE = 12;
  localparam int ESW = 4;
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NE-1:0]     event_i = '0;
  logic [NC-1:0]     inhibit_i = '0;
  logic [1:0]        idx_i = '0;
  logic              cnt_we_i = 1'b0;
  logic              cnth_we_i = 1'b0;
  logic              evsel_we_i = 1'b0;
  logic [NC-1:0]     ovf_clr_i = '0;
  logic [NC-1:0]     ovf_ie_i = '0;
  logic [31:0]       wdata = '0;
  logic [NC*64-1:0]  counter_val_o;
  logic [NC*ESW-1:0] evsel_o;
  logic [NC-1:0]     ovf_o;
  logic              irq_o;

  int total = 0;
  int bad = 0;

  logic [63:0] m_cnt [NC] = '{default: 64'd0};
  int unsigned m_evsel [NC] = '{default: 0};
  logic [NC-1:0] m_ovf = '0;

  ibex_counter_bank #(
    .NumCounters  (NC),
    .CounterWidth (CW),
    .NumEvents    (NE)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .event_i       (event_i),
    .inhibit_i     (inhibit_i),
    .idx_i         (idx_i),
    .cnt_we_i      (cnt_we_i),
    .cnth_we_i     (cnth_we_i),
    .evsel_we_i    (evsel_we_i),
    .ovf_clr_i     (ovf_clr_i),
    .ovf_ie_i      (ovf_ie_i),
    .csr_wdata_i   (wdata),
    .counter_val_o (counter_val_o),
    .evsel_o       (evsel_o),
    .ovf_o         (ovf_o),
    .irq_o         (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the spec's rules applied per counter with plain arithmetic.
  always @(posedge clk or negedge rst_n) begin
    logic [63:0] v;
    logic        hit, wr, wrap;
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) begin
        m_cnt[k] = 64'd0;
        m_evsel[k] = 0;
      end
      m_ovf = '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        hit  = (m_evsel[k] < NE) && event_i[m_evsel[k]] && !inhibit_i[k];
        wr   = (int'(idx_i) == k) && (cnt_we_i || cnth_we_i);
        wrap = 1'b0;
        v    = m_cnt[k];
        if (wr) begin
          if (cnth_we_i) v = (v & 64'h0000_0000_FFFF_FFFF) | ({32'd0, wdata} << 32);
          else           v = (v & 64'hFFFF_FFFF_0000_0000) | {32'd0, wdata};
          v = v & MASK;
        end else if (hit) begin
          if (v == MASK) begin
            v = 64'd0;
            wrap = 1'b1;
          end else begin
            v = v + 64'd1;
          end
        end
        m_cnt[k] = v;
        if ((int'(idx_i) == k) && evsel_we_i) m_evsel[k] = wdata % 16;
        m_ovf[k] = wrap | (m_ovf[k] & !ovf_clr_i[k]);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("cnt%0d", k), counter_val_o[64*k +: 64], m_cnt[k]);
      chk($sformatf("evsel%0d", k), 64'(evsel_o[ESW*k +: ESW]), 64'(m_evsel[k]));
      chk($sformatf("ovf%0d", k), 64'(ovf_o[k]), 64'(m_ovf[k]));
    end
    chk("irq", 64'(irq_o), 64'(|(m_ovf & ovf_ie_i)));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    event_i = '0; inhibit_i = '0; idx_i = '0;
    cnt_we_i = 1'b0; cnth_we_i = 1'b0; evsel_we_i = 1'b0;
    ovf_clr_i = '0; wdata = '0;
  endtask

  task automatic wr_cnt(input logic [1:0] idx, input logic hi, input logic [31:0] d);
    idle();
    idx_i = idx; cnt_we_i = !hi; cnth_we_i = hi; wdata = d;
    step();
    idle();
  endtask

  function automatic logic [63:0] cval(input int k);
    return counter_val_o[64*k +: 64];
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      event_i = 12'($urandom);
      step();
    end
    chk("rst_cnt", 64'(counter_val_o), 64'd0);
    chk("rst_misc", 64'({evsel_o, ovf_o, irq_o}), 64'd0);
    idle();
    rst_n = 1'b1;
    step();
    chk("post_rst_cnt0", cval(0), 64'd0);

    // Count with select 3; event 2 must be ignored.
    idle(); idx_i = 2'd0; evsel_we_i = 1'b1; wdata = 32'd3; step(); idle();
    for (int i = 0; i < 5; i++) begin
      event_i = (i < 4) ? 12'b1100 : 12'b1000;
      step();
    end
    idle();
    chk("count5", cval(0), 64'd5);

    wr_cnt(2'd0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      event_i = 12'b1000; inhibit_i = (i < 2) ? 3'b001 : 3'b000;
      step();
    end
    idle();
    chk("count_inh", cval(0), 64'd3);

    // Wrap to zero sets the flag and raises irq in the same cycle.
    ovf_ie_i = 3'b010;
    wr_cnt(2'd1, 1'b0, 32'hFFFF_FFFF);
    wr_cnt(2'd1, 1'b1, 32'h0000_00FF);
    chk("pre_wrap", cval(1), 64'h0000_00FF_FFFF_FFFF);
    chk("pre_wrap_irq", 64'(irq_o), 64'd0);
    event_i = 12'b1; step(); idle();
    chk("wrap_cnt", cval(1), 64'd0);
    chk("wrap_ovf", 64'(ovf_o), 64'b010);
    chk("wrap_irq", 64'(irq_o), 64'd1);
    ovf_clr_i = 3'b010; step(); idle();
    chk("clr_ovf", 64'(ovf_o[1]), 64'd0);
    chk("clr_irq", 64'(irq_o), 64'd0);

    wr_cnt(2'd1, 1'b0, 32'hFFFF_FFFF);
    wr_cnt(2'd1, 1'b1, 32'h0000_00FF);
    event_i = 12'b1; ovf_clr_i = 3'b010; step(); idle();
    chk("set_beats_clr", 64'(ovf_o[1]), 64'd1);
    chk("set_beats_clr_irq", 64'(irq_o), 64'd1);

    // Write beats increment on the same counter.
    event_i = 12'b1; idx_i = 2'd2; cnt_we_i = 1'b1; wdata = 32'h10; step(); idle();
    chk("wr_over_inc", cval(2), 64'h10);
    chk("other_inc", cval(1), 64'd1);

    wr_cnt(2'd2, 1'b1, 32'hFFFF_FFFF);
    chk("width_mask", cval(2), 64'h0000_00FF_0000_0010);

    // Index beyond the bank is ignored entirely.
    idle(); idx_i = 2'd3; cnt_we_i = 1'b1; cnth_we_i = 1'b1; evsel_we_i = 1'b1;
    wdata = 32'h5; step(); idle();
    chk("oor_cnt0", cval(0), 64'd3);
    chk("oor_cnt2", cval(2), 64'h0000_00FF_0000_0010);
    chk("oor_evsel", 64'(evsel_o), 64'h003);

    // Select beyond the event inputs never counts.
    idle(); idx_i = 2'd0; evsel_we_i = 1'b1; wdata = 32'd12; step(); idle();
    for (int i = 0; i < 3; i++) begin
      event_i = '1; step();
    end
    idle();
    chk("evsel_oor", cval(0), 64'd3);
    chk("evsel_oor_sel", 64'(evsel_o), 64'h00C);
    chk("evsel_oor_other", cval(1), 64'd4);

    for (int i = 0; i < 1500; i++) begin
      event_i    = 12'($urandom);
      inhibit_i  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      idx_i      = 2'($urandom);
      cnt_we_i   = ($urandom_range(0, 4) == 0);
      cnth_we_i  = ($urandom_range(0, 5) == 0);
      evsel_we_i = ($urandom_range(0, 7) == 0);
      ovf_clr_i  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      ovf_ie_i   = 3'($urandom);
      case ($urandom_range(0, 4))
        0:       wdata = $urandom;
        1:       wdata = 32'hFFFF_FFFF;
        2:       wdata = 32'hFFFF_FFF0;
        3:       wdata = 32'h0000_00FF;
        default: wdata = 32'($urandom_range(0, 15));
      endcase
      if (i == 703) rst_n = 1'b1;
      if (i == 700) begin
        #1 rst_n = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
